// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mc_ctrl_pkg                                                |
// | Brief   : State encodings, opcodes, select constants and the control |
// |           word shared by the multi-cycle MIPS control FSM.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mc_ctrl_pkg;

  // FSM state encodings; 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // ALU operation requested from the ALU control unit
  localparam logic [1:0] c_alu_add   = 2'b00;
  localparam logic [1:0] c_alu_sub   = 2'b01;
  localparam logic [1:0] c_alu_funct = 2'b10;

  // ALU B operand select
  localparam logic [1:0] c_alub_reg       = 2'b00;
  localparam logic [1:0] c_alub_four      = 2'b01;
  localparam logic [1:0] c_alub_imm       = 2'b10;
  localparam logic [1:0] c_alub_imm_shift = 2'b11;

  // PC source select
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // Complete set of datapath controls produced in one cycle
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mc_ctrl_decode                                             |
// | Brief   : Combinational control-word decode from the FSM state.      |
// |           Macro MC_JUMP_EN adds the JUMP state controls.             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_zero,
  input  logic   i_rst,
  output ctrl_t  o_ctrl
);

  ctrl_t w_ctrl;

  // Moore control word per state, plus the mem_ready / zero qualified enables
  always_comb begin
    w_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.i_or_d    = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = c_alub_four;
        w_ctrl.alu_op    = c_alu_add;
        w_ctrl.pc_source = c_pcsrc_alu;
        w_ctrl.ir_write  = i_mem_ready;
        w_ctrl.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = c_alub_imm_shift;
        w_ctrl.alu_op    = c_alu_add;
      end
      ST_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = c_alub_imm;
        w_ctrl.alu_op    = c_alu_add;
      end
      ST_MEM_READ: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
      end
      ST_MEM_WRITE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = c_alub_reg;
        w_ctrl.alu_op    = c_alu_funct;
      end
      ST_R_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = c_alub_reg;
        w_ctrl.alu_op    = c_alu_sub;
        w_ctrl.pc_source = c_pcsrc_aluout;
        w_ctrl.pc_write  = i_zero;
      end
`ifdef MC_JUMP_EN
      ST_JUMP: begin
        w_ctrl.pc_source = c_pcsrc_jump;
        w_ctrl.pc_write  = 1'b1;
      end
`endif
      ST_ADDI_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = c_alub_imm;
        w_ctrl.alu_op    = c_alu_add;
      end
      ST_ADDI_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Reset holds every architectural strobe low; reset is asynchronous, so
  // the FETCH read request must not leak out while rst is still high
  always_comb begin
    o_ctrl = w_ctrl;
    if (i_rst) begin
      o_ctrl.pc_write  = 1'b0;
      o_ctrl.ir_write  = 1'b0;
      o_ctrl.mem_read  = 1'b0;
      o_ctrl.mem_write = 1'b0;
      o_ctrl.reg_write = 1'b0;
    end
  end

endmodule : mc_ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multicycle_ctrl_fsm                                        |
// | Brief   : Main control FSM for the multi-cycle MIPS datapath: state  |
// |           register, next-state logic and fetched-instruction count.  |
// |           Macro MC_JUMP_EN enables decode of j (opcode 000010).      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_illegal;
  logic [31:0] r_instr_count;
  ctrl_t       w_ctrl;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    w_next_state = ST_FETCH;
    w_illegal    = 1'b0;
    case (r_state)
      ST_FETCH: w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          c_op_rtype:       w_next_state = ST_R_EXEC;
          c_op_lw, c_op_sw: w_next_state = ST_MEM_ADDR;
          c_op_beq:         w_next_state = ST_BRANCH;
          c_op_addi:        w_next_state = ST_ADDI_EXEC;
`ifdef MC_JUMP_EN
          c_op_j:           w_next_state = ST_JUMP;
`endif
          default: begin
            w_next_state = ST_FETCH;
            w_illegal    = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        if (opcode == c_op_lw) begin
          w_next_state = ST_MEM_READ;
        end else if (opcode == c_op_sw) begin
          w_next_state = ST_MEM_WRITE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_MEM_READ:  w_next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: w_next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    w_next_state = ST_R_WB;
      ST_ADDI_EXEC: w_next_state = ST_ADDI_WB;
      default:      w_next_state = ST_FETCH;
    endcase
  end

  // Fetched-instruction counter; wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= 32'd0;
    end else if (w_ctrl.ir_write) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_zero      (zero),
    .i_rst       (rst),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write    = w_ctrl.pc_write;
  assign ir_write    = w_ctrl.ir_write;
  assign i_or_d      = w_ctrl.i_or_d;
  assign mem_read    = w_ctrl.mem_read;
  assign mem_write   = w_ctrl.mem_write;
  assign mem_to_reg  = w_ctrl.mem_to_reg;
  assign reg_dst     = w_ctrl.reg_dst;
  assign reg_write   = w_ctrl.reg_write;
  assign alu_src_a   = w_ctrl.alu_src_a;
  assign alu_src_b   = w_ctrl.alu_src_b;
  assign alu_op      = w_ctrl.alu_op;
  assign pc_source   = w_ctrl.pc_source;
  assign illegal_op  = w_illegal & ~rst;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule : multicycle_ctrl_fsm
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_multicycle_ctrl_fsm                                     |
// | Brief   : Directed bench for multicycle_ctrl_fsm with a route-table  |
// |           reference model compared every cycle. Honours MC_JUMP_EN.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_multicycle_ctrl_fsm;

`ifdef MC_JUMP_EN
  localparam bit JUMP_ON = 1'b1;
`else
  localparam bit JUMP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Route of each instruction after DECODE, one state per nibble, low first;
  // a zero nibble means back to FETCH. An empty route marks an illegal opcode.
  function automatic logic [15:0] route_of(input logic [5:0] op);
    case (op)
      6'b000000: return 16'h0076;   // R_EXEC, R_WB
      6'b100011: return 16'h0432;   // MEM_ADDR, MEM_READ, MEM_WB
      6'b101011: return 16'h0052;   // MEM_ADDR, MEM_WRITE
      6'b000100: return 16'h0008;   // BRANCH
      6'b001000: return 16'h00BA;   // ADDI_EXEC, ADDI_WB
      6'b000010: return JUMP_ON ? 16'h0009 : 16'h0000;
      default:   return 16'h0000;
    endcase
  endfunction

  function automatic int route_step(input logic [15:0] r, input int i);
    return int'(r[i*4 +: 4]);
  endfunction

  // Expected control vector:
  // {illegal, pcw, irw, iord, mread, mwrite, m2r, rdst, rwrite, srcA, srcB[2], aluop[2], pcs[2]}
  function automatic logic [15:0] exp_ctl(input int st, input logic rdy, input logic z,
                                          input logic [5:0] op, input logic r);
    logic [15:0] v;
    v = '0;
    case (st)
      0:  begin v[14] = rdy; v[13] = rdy; v[11] = 1'b1; v[5:4] = 2'b01; end
      1:  begin v[5:4] = 2'b11; v[15] = (route_of(op) == 16'h0); end
      2:  begin v[6] = 1'b1; v[5:4] = 2'b10; end
      3:  begin v[12] = 1'b1; v[11] = 1'b1; end
      4:  begin v[9] = 1'b1; v[7] = 1'b1; end
      5:  begin v[12] = 1'b1; v[10] = 1'b1; end
      6:  begin v[6] = 1'b1; v[3:2] = 2'b10; end
      7:  begin v[8] = 1'b1; v[7] = 1'b1; end
      8:  begin v[6] = 1'b1; v[3:2] = 2'b01; v[1:0] = 2'b01; v[14] = z; end
      9:  begin v[14] = 1'b1; v[1:0] = 2'b10; end
      10: begin v[6] = 1'b1; v[5:4] = 2'b10; end
      11: v[7] = 1'b1;
      default: v = '0;
    endcase
    if (r) begin
      v[15] = 1'b0; v[14] = 1'b0; v[13] = 1'b0;
      v[11] = 1'b0; v[10] = 1'b0; v[7] = 1'b0;
    end
    return v;
  endfunction

  // Reference model: position within the current instruction's route
  int          m_state = 0;
  int          m_step  = 0;
  logic [15:0] m_route = '0;
  logic [31:0] m_count = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_step  <= 0;
      m_route <= '0;
      m_count <= '0;
    end else if (m_state == 0) begin
      if (mem_ready) begin
        m_count <= m_count + 32'd1;
        m_state <= 1;
      end
    end else if (m_state == 1) begin
      m_route <= route_of(opcode);
      m_state <= route_step(route_of(opcode), 0);
      m_step  <= 1;
    end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
      m_state <= m_state;
    end else begin
      m_state <= route_step(m_route, m_step);
      m_step  <= m_step + 1;
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    check("model_state", {28'd0, state}, m_state);
    check("model_ctl",
          {16'd0, illegal_op, pc_write, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source},
          {16'd0, exp_ctl(m_state, mem_ready, zero, opcode, rst)});
    check("model_count", instr_count, m_count);
  end

  // One cycle: drive inputs after the edge, check the state mid-cycle
  task automatic tick(input logic rdy, input logic z, input logic [3:0] exp_st, input string tag);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    check(tag, {28'd0, state}, {28'd0, exp_st});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_count", instr_count, 32'd0);

    // R-type with one fetch stall
    opcode = 6'b000000;
    tick(0, 0, 4'd0, "r_stall");
    check("r_stall_irw", {31'd0, ir_write}, 32'd0);
    tick(1, 0, 4'd0, "r_fetch");
    check("r_fetch_irw_pcw", {30'd0, ir_write, pc_write}, 32'd3);
    tick(1, 0, 4'd1, "r_decode");
    tick(1, 0, 4'd6, "r_exec");
    check("r_exec_aluop", {30'd0, alu_op}, 32'd2);
    tick(1, 0, 4'd7, "r_wb");
    check("r_wb_write_dst", {30'd0, reg_write, reg_dst}, 32'd3);
    tick(0, 0, 4'd0, "r_done");
    check("r_count", instr_count, 32'd1);

    // lw with two wait states in MEM_READ: seven cycles
    opcode = 6'b100011;
    tick(1, 0, 4'd0, "lw_fetch");
    tick(1, 0, 4'd1, "lw_decode");
    tick(1, 0, 4'd2, "lw_addr");
    for (int k = 0; k < 3; k++) begin
      tick(k == 2, 0, 4'd3, "lw_read");
      check("lw_read_mread_iord", {30'd0, mem_read, i_or_d}, 32'd3);
    end
    tick(1, 0, 4'd4, "lw_wb");
    check("lw_wb_m2r_write", {30'd0, mem_to_reg, reg_write}, 32'd3);
    tick(0, 0, 4'd0, "lw_done");
    check("lw_count", instr_count, 32'd2);

    // beq taken and not taken
    opcode = 6'b000100;
    for (int t = 1; t >= 0; t--) begin
      tick(1, 0, 4'd0, "beq_fetch");
      tick(1, 0, 4'd1, "beq_decode");
      tick(1, t[0], 4'd8, "beq_branch");
      check("beq_pcw_pcsrc", {29'd0, pc_write, pc_source}, {29'd0, t[0], 2'b01});
      tick(0, 0, 4'd0, "beq_done");
    end
    check("beq_count", instr_count, 32'd4);

    // Illegal opcode
    opcode = 6'b111111;
    tick(1, 0, 4'd0, "ill_fetch");
    tick(1, 0, 4'd1, "ill_decode");
    check("ill_pulse", {31'd0, illegal_op}, 32'd1);
    tick(0, 0, 4'd0, "ill_done");
    check("ill_after", {29'd0, illegal_op, reg_write, mem_write}, 32'd0);

    // Jump: decoded only when the jump feature is built
    opcode = 6'b000010;
    tick(1, 0, 4'd0, "j_fetch");
    tick(1, 0, 4'd1, "j_decode");
    if (JUMP_ON) begin
      check("j_no_illegal", {31'd0, illegal_op}, 32'd0);
      tick(1, 0, 4'd9, "j_jump");
      check("j_pcw_pcsrc", {29'd0, pc_write, pc_source}, 32'h6);
    end else begin
      check("j_illegal", {31'd0, illegal_op}, 32'd1);
    end
    tick(0, 0, 4'd0, "j_done");
    check("j_count", instr_count, 32'd6);

    // sw interrupted by reset while waiting in MEM_WRITE
    opcode = 6'b101011;
    tick(1, 0, 4'd0, "sw_fetch");
    tick(1, 0, 4'd1, "sw_decode");
    tick(1, 0, 4'd2, "sw_addr");
    tick(0, 0, 4'd5, "sw_write");
    check("sw_mem_write", {31'd0, mem_write}, 32'd1);
    check("sw_count", instr_count, 32'd7);
    #1 rst = 1'b1;
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_strobes", {27'd0, mem_write, mem_read, ir_write, pc_write, reg_write}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // addi after reset starts from a clean FETCH
    opcode = 6'b001000;
    tick(0, 0, 4'd0, "addi_idle");
    tick(1, 0, 4'd0, "addi_fetch");
    tick(1, 0, 4'd1, "addi_decode");
    tick(1, 0, 4'd10, "addi_exec");
    check("addi_exec_srcb", {30'd0, alu_src_b}, 32'd2);
    tick(1, 0, 4'd11, "addi_wb");
    check("addi_wb_write_dst", {30'd0, reg_write, reg_dst}, 32'd2);
    tick(0, 0, 4'd0, "addi_done");
    check("addi_count", instr_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multicycle_ctrl_fsm
`default_nettype wire

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control state machine for the multi-cycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, the register-file and memory strobes, and the 2-bit `alu_op` consumed by the ALU control unit. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: IR load enable.
- `i_or_d` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `mem_to_reg` out 1: writeback select (1 = MDR).
- `reg_dst` out 1: destination register select (1 = rd).
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select (0 = PC, 1 = A).
- `alu_src_b` out 2: ALU B select (00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate).
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = decode funct.
- `pc_source` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: unsupported opcode seen in DECODE.
- `state` out 4: current state, for debug.
- `instr_count` out 32: count of fetched instructions.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11.
- Unencoded states (12–15) go to FETCH on the next edge, with all outputs 0.
- Unlisted outputs are 0 in every state.
- **FETCH**
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- **DECODE**
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state: R-type → R_EXEC; lw or sw → MEM_ADDR; beq → BRANCH; addi → ADDI_EXEC; j → JUMP.
  - Any other opcode: illegal_op=1 for this cycle, then FETCH.
- **MEM_ADDR**
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: lw → MEM_READ; sw → MEM_WRITE.
- **MEM_READ**
  - Outputs: mem_read=1, i_or_d=1.
  - Waits for mem_ready, then MEM_WB.
- **MEM_WB**
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next state: FETCH.
- **MEM_WRITE**
  - Outputs: mem_write=1, i_or_d=1.
  - Waits for mem_ready, then FETCH.
- **R_EXEC**
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: R_WB.
- **R_WB**
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Next state: FETCH.
- **BRANCH**
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero.
  - Next state: FETCH.
- **JUMP**
  - Outputs: pc_source=10, pc_write=1.
  - Next state: FETCH.
- **ADDI_EXEC**
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: ADDI_WB.
- **ADDI_WB**
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Next state: FETCH.
- **instr_count**
  - Increments on every edge where ir_write=1.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - state=FETCH and instr_count=0 asynchronously.
  - While rst=1, all read/write strobes (pc_write, ir_write, mem_read, mem_write, reg_write) and illegal_op are forced to 0.
- Reset deasserted mid-instruction: execution resumes at FETCH, and the partial instruction has no further effect.
- Outputs are Moore-decoded from the state register, except the combinational terms ir_write/pc_write (mem_ready) in FETCH and pc_write (zero) in BRANCH.
- Minimum cycles per instruction with zero wait states:
  - beq 3, j 3
  - R-type 4, addi 4, sw 4
  - lw 5
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- opcode must be held stable from DECODE until the instruction returns to FETCH.

## Configuration
- Macro: `MC_JUMP_EN`.
- Defined: j (000010) is decoded to JUMP and pc_source=10 is reachable.
- Undefined:
  - The JUMP state is not built.
  - j is illegal: illegal_op pulses and the FSM returns to FETCH.
  - pc_source never drives 10.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - state encodings;
  - opcode constants;
  - alu_op constants (ADD=00, SUB=01, FUNCT=10);
  - alu_src_b and pc_source select constants.
- One sub-module, `mc_ctrl_decode`: combinational map from state, mem_ready, zero and rst to all control outputs. The top level holds the state register, the next-state logic and instr_count.

## Test plan
- **R-type, mem_ready=1:** opcode 000000 → states 0,1,6,7,0; alu_op=10 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB; instr_count=1.
- **lw with 2 wait states in MEM_READ:** opcode 100011 → 7 cycles total; mem_read and i_or_d held high for 3 cycles; mem_to_reg=1 and reg_write=1 in MEM_WB.
- **beq:** opcode 000100 with zero=1 → pc_write=1 and pc_source=01 in BRANCH; with zero=0 → pc_write=0; both return to FETCH after 3 cycles.
- **Illegal opcode:** opcode 111111 → illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no reg_write or mem_write.
- **Mid-MEM_WRITE reset:** rst asserted during MEM_WRITE → state=0 immediately, mem_write=0 the same cycle, instr_count=0.
- **Jump configuration:** with `MC_JUMP_EN`, opcode 000010 → pc_write=1 and pc_source=10 in state 9; without it → illegal_op pulse.
